// File: rtl/wb_exc_ctrl.sv
// Writeback-stage exception/interrupt commit controller with a flush/redirect handshake toward fetch.
// Optional feature macro: WB_EXC_INT_EN enables interrupt sampling and the INT priority level.
module wb_exc_ctrl #(
  parameter int unsigned PC_W = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            wb_valid,
  input  logic [PC_W-1:0] wb_pc,
  input  logic [4:0]      wb_exc_flags,
  input  logic            wb_ertn,
  input  logic [PC_W-1:0] wb_vaddr,
  input  logic [12:0]     csr_estat_is,
  input  logic [12:0]     csr_ecfg_lie,
  input  logic            csr_crmd_ie,
  input  logic [PC_W-1:0] csr_era_pc,
  input  logic [PC_W-1:0] csr_eentry,
  output logic            wb_ex,
  output logic [5:0]      wb_ecode,
  output logic [7:0]      wb_esubcode,
  output logic            wb_ex_ale,
  output logic [PC_W-1:0] wb_ex_ale_addr,
  output logic            wb_ertn_flush,
  output logic            wb_allowin,
  output logic            flush_valid,
  output logic [PC_W-1:0] flush_pc,
  input  logic            flush_ready
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;
  localparam logic [5:0] ECODE_BRK  = 6'h0C;
  localparam logic [5:0] ECODE_INE  = 6'h0D;

  logic [0:0] state;
  logic       int_pend_q;
  logic       is_idle;
  logic       commit_ex;
  logic       commit_ertn;
  logic       flag_adef;
  logic       flag_ine;
  logic       flag_sys;
  logic       flag_brk;
  logic       flag_ale;
  logic       unused_bits;

  assign flag_adef = wb_exc_flags[4];
  assign flag_ine  = wb_exc_flags[3];
  assign flag_sys  = wb_exc_flags[2];
  assign flag_brk  = wb_exc_flags[1];
  assign flag_ale  = wb_exc_flags[0];

`ifdef WB_EXC_INT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      int_pend_q <= 1'b0;
    end else begin
      int_pend_q <= csr_crmd_ie & (|(csr_estat_is & csr_ecfg_lie));
    end
  end

  assign unused_bits = ^wb_pc;
`else
  assign int_pend_q  = 1'b0;
  assign unused_bits = ^{wb_pc, csr_estat_is, csr_ecfg_lie, csr_crmd_ie};
`endif

  assign is_idle     = (state == S_IDLE);
  assign commit_ex   = is_idle & wb_valid & (int_pend_q | (|wb_exc_flags));
  assign commit_ertn = is_idle & wb_valid & wb_ertn & ~commit_ex;

  // Cause selection; all codes stay zero unless an exception actually commits.
  always_comb begin
    wb_ecode    = '0;
    wb_esubcode = '0;
    wb_ex_ale   = 1'b0;
    if (commit_ex) begin
      if (int_pend_q) begin
        wb_ecode = ECODE_INT;
      end else if (flag_adef) begin
        wb_ecode = ECODE_ADEF;
      end else if (flag_ine) begin
        wb_ecode = ECODE_INE;
      end else if (flag_sys) begin
        wb_ecode = ECODE_SYS;
      end else if (flag_brk) begin
        wb_ecode = ECODE_BRK;
      end else if (flag_ale) begin
        wb_ecode  = ECODE_ALE;
        wb_ex_ale = 1'b1;
      end
    end
  end

  assign wb_ex          = commit_ex;
  assign wb_ertn_flush  = commit_ertn;
  assign wb_ex_ale_addr = wb_vaddr;
  assign wb_allowin     = is_idle;

  // Target is captured from the CSR values seen before the commit edge updates them.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      flush_valid <= 1'b0;
      flush_pc    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (commit_ex || commit_ertn) begin
            state       <= S_FLUSH;
            flush_valid <= 1'b1;
            flush_pc    <= commit_ex ? csr_eentry : csr_era_pc;
          end
        end
        S_FLUSH: begin
          if (flush_valid && flush_ready) begin
            state       <= S_IDLE;
            flush_valid <= 1'b0;
          end
        end
        default: begin
          state       <= S_IDLE;
          flush_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_exc_ctrl.sv
// Self-checking bench for wb_exc_ctrl: vector table for commit decoding plus handshake/reset sequences.
module tb_wb_exc_ctrl;

  localparam logic [31:0] EENTRY = 32'h1C00_8000;
  localparam logic [31:0] ERA    = 32'h1C00_0100;

  logic        clk;
  logic        resetn;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic [4:0]  wb_exc_flags;
  logic        wb_ertn;
  logic [31:0] wb_vaddr;
  logic [12:0] csr_estat_is;
  logic [12:0] csr_ecfg_lie;
  logic        csr_crmd_ie;
  logic [31:0] csr_era_pc;
  logic [31:0] csr_eentry;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [7:0]  wb_esubcode;
  logic        wb_ex_ale;
  logic [31:0] wb_ex_ale_addr;
  logic        wb_ertn_flush;
  logic        wb_allowin;
  logic        flush_valid;
  logic [31:0] flush_pc;
  logic        flush_ready;

  int total;
  int bad;
  logic [31:0] exp_q[$];

  wb_exc_ctrl #(.PC_W(32)) dut (
    .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_pc(wb_pc),
    .wb_exc_flags(wb_exc_flags), .wb_ertn(wb_ertn), .wb_vaddr(wb_vaddr),
    .csr_estat_is(csr_estat_is), .csr_ecfg_lie(csr_ecfg_lie), .csr_crmd_ie(csr_crmd_ie),
    .csr_era_pc(csr_era_pc), .csr_eentry(csr_eentry), .wb_ex(wb_ex), .wb_ecode(wb_ecode),
    .wb_esubcode(wb_esubcode), .wb_ex_ale(wb_ex_ale), .wb_ex_ale_addr(wb_ex_ale_addr),
    .wb_ertn_flush(wb_ertn_flush), .wb_allowin(wb_allowin), .flush_valid(flush_valid),
    .flush_pc(flush_pc), .flush_ready(flush_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Redirects are checked against the queued target when fetch accepts them.
  always @(negedge clk) begin
    if (resetn && flush_valid && flush_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_redirect actual=%h required=none", flush_pc);
      end else begin
        chk("redirect_pc", flush_pc, exp_q.pop_front());
      end
    end
  end

  typedef struct {
    logic        valid;
    logic [4:0]  flags;
    logic        ertn;
    logic [31:0] vaddr;
    logic        ex;
    logic [5:0]  ecode;
    logic        ale;
    logic        ertn_flush;
    logic [31:0] target;
  } vec_t;

  vec_t vecs[9];

  task automatic clear_wb();
    wb_valid     = 1'b0;
    wb_exc_flags = '0;
    wb_ertn      = 1'b0;
  endtask

  // Drive one instruction in IDLE, check strobes, then the redirect and the return to IDLE.
  task automatic run_instr(input string tag, input logic valid, input logic [4:0] flags,
                           input logic ertn, input logic [31:0] vaddr, input logic ex,
                           input logic [5:0] ecode, input logic ale, input logic ertn_flush,
                           input logic [31:0] target);
    logic commit;
    commit = ex | ertn_flush;
    @(posedge clk); #1;
    wb_valid = valid; wb_exc_flags = flags; wb_ertn = ertn; wb_vaddr = vaddr;
    #1;
    chk({tag, ".allowin"}, 32'(wb_allowin), 32'd1);
    chk({tag, ".ex"}, 32'(wb_ex), 32'(ex));
    chk({tag, ".ecode"}, 32'(wb_ecode), 32'(ecode));
    chk({tag, ".esub"}, 32'(wb_esubcode), 32'd0);
    chk({tag, ".ale"}, 32'(wb_ex_ale), 32'(ale));
    chk({tag, ".ale_addr"}, wb_ex_ale_addr, vaddr);
    chk({tag, ".ertn_flush"}, 32'(wb_ertn_flush), 32'(ertn_flush));
    if (commit) exp_q.push_back(target);
    @(posedge clk); #1;
    chk({tag, ".flush_valid"}, 32'(flush_valid), 32'(commit));
    clear_wb();
    @(posedge clk); #1;
    chk({tag, ".idle_again"}, 32'(wb_allowin), 32'd1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    resetn = 1'b0;
    clear_wb();
    wb_pc = 32'h1C00_0000; wb_vaddr = '0;
    csr_estat_is = '0; csr_ecfg_lie = '0; csr_crmd_ie = 1'b0;
    csr_era_pc = ERA; csr_eentry = EENTRY;
    flush_ready = 1'b1;

    //                valid flags     ertn vaddr          ex ecode  ale eflush target
    vecs[0] = '{1'b1, 5'b00001, 1'b0, 32'h1C00_0003, 1'b1, 6'h09, 1'b1, 1'b0, EENTRY};
    vecs[1] = '{1'b1, 5'b00000, 1'b1, 32'h0000_0000, 1'b0, 6'h00, 1'b0, 1'b1, ERA};
    vecs[2] = '{1'b1, 5'b10110, 1'b0, 32'h0000_0010, 1'b1, 6'h08, 1'b0, 1'b0, EENTRY};
    vecs[3] = '{1'b1, 5'b00110, 1'b0, 32'h0000_0020, 1'b1, 6'h0B, 1'b0, 1'b0, EENTRY};
    vecs[4] = '{1'b1, 5'b01001, 1'b0, 32'h0000_0031, 1'b1, 6'h0D, 1'b0, 1'b0, EENTRY};
    vecs[5] = '{1'b1, 5'b00010, 1'b0, 32'h0000_0040, 1'b1, 6'h0C, 1'b0, 1'b0, EENTRY};
    vecs[6] = '{1'b0, 5'b00100, 1'b0, 32'h0000_0050, 1'b0, 6'h00, 1'b0, 1'b0, 32'h0};
    vecs[7] = '{1'b1, 5'b00100, 1'b1, 32'h0000_0060, 1'b1, 6'h0B, 1'b0, 1'b0, EENTRY};
    vecs[8] = '{1'b1, 5'b00000, 1'b0, 32'h0000_0070, 1'b0, 6'h00, 1'b0, 1'b0, 32'h0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst.flush_valid", 32'(flush_valid), 32'd0);
    chk("rst.flush_pc", flush_pc, 32'd0);
    chk("rst.allowin", 32'(wb_allowin), 32'd1);
    chk("rst.ex", 32'(wb_ex), 32'd0);
    resetn = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_instr($sformatf("vec%0d", i), vecs[i].valid, vecs[i].flags, vecs[i].ertn,
                vecs[i].vaddr, vecs[i].ex, vecs[i].ecode, vecs[i].ale,
                vecs[i].ertn_flush, vecs[i].target);
    end

    // Interrupt enabled and pending: tagged onto the next valid instruction.
    @(posedge clk); #1;
    csr_crmd_ie = 1'b1; csr_estat_is = 13'h0800; csr_ecfg_lie = 13'h0800;
`ifdef WB_EXC_INT_EN
    run_instr("int_sys", 1'b1, 5'b00100, 1'b0, 32'h0, 1'b1, 6'h00, 1'b0, 1'b0, EENTRY);
    run_instr("int_ertn", 1'b1, 5'b00000, 1'b1, 32'h0, 1'b1, 6'h00, 1'b0, 1'b0, EENTRY);
`else
    run_instr("int_sys", 1'b1, 5'b00100, 1'b0, 32'h0, 1'b1, 6'h0B, 1'b0, 1'b0, EENTRY);
    run_instr("int_ertn", 1'b1, 5'b00000, 1'b1, 32'h0, 1'b0, 6'h00, 1'b0, 1'b1, ERA);
`endif
    csr_crmd_ie = 1'b0;
    @(posedge clk); #1;
    run_instr("noie_sys", 1'b1, 5'b00100, 1'b0, 32'h0, 1'b1, 6'h0B, 1'b0, 1'b0, EENTRY);
    csr_estat_is = '0; csr_ecfg_lie = '0;

    // Backpressure: redirect held, WB blocked, CSR changes must not leak into flush_pc.
    @(posedge clk); #1;
    flush_ready = 1'b0;
    wb_valid = 1'b1; wb_exc_flags = 5'b00100;
    exp_q.push_back(EENTRY);
    @(posedge clk); #1;
    csr_eentry = 32'h1C00_9000;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp.flush_valid", 32'(flush_valid), 32'd1);
      chk("bp.flush_pc", flush_pc, EENTRY);
      chk("bp.allowin", 32'(wb_allowin), 32'd0);
      chk("bp.no_ex", 32'(wb_ex), 32'd0);
      @(posedge clk); #1;
    end
    clear_wb();
    flush_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp.release_allowin", 32'(wb_allowin), 32'd1);
    chk("bp.release_fv", 32'(flush_valid), 32'd0);
    csr_eentry = EENTRY;

    // Reset mid-FLUSH drops the redirect immediately.
    flush_ready = 1'b0;
    wb_valid = 1'b1; wb_exc_flags = 5'b00010;
    @(posedge clk); #1;
    clear_wb();
    chk("rstf.flush_valid_before", 32'(flush_valid), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("rstf.flush_valid", 32'(flush_valid), 32'd0);
    chk("rstf.allowin", 32'(wb_allowin), 32'd1);
    chk("rstf.flush_pc", flush_pc, 32'd0);
    #3;
    resetn = 1'b1;
    flush_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("end.queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
